ddr_read_scheduler: RTL and testbench

DDR_READ_SCHEDULER -- requirements
Module: ddr_read_scheduler

---
 rtl/ddr_pkg.sv | 18 +
 rtl/ddr_id_queue.sv | 58 +++++
 rtl/ddr_read_scheduler.sv | 145 ++++++++++++++
 tb/tb_ddr_read_scheduler.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_pkg.sv
// Shared types and constants for the DDR read scheduler: FSM states, command/ID widths
// and the sizing rule for the read-data credit counter.
package ddr_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    localparam int LEN_WIDTH = 8;
    localparam int ID_WIDTH  = 1;

    // One extra bit over the FIFO pointer so a completely free FIFO is representable.
    function automatic int credit_width(input int fifo_awidth);
        return fifo_awidth + 1;
    endfunction

endpackage

// File: rtl/ddr_id_queue.sv
// Synchronous FIFO holding the requester ID of every burst that is still waiting for
// its last read beat; the head entry steers returning data.
module ddr_id_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_id,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    // NOTE: storage is deliberately not reset; an entry is only read after count shows it was written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_id;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ddr_read_scheduler.sv
// Two-requester DDR read scheduler: round-robin admission gated by read-FIFO credit and
// ID-queue space, single-command issue, and ID-ordered routing of returning beats.
module ddr_read_scheduler
    import ddr_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 16,
    parameter int ADDR_WIDTH     = 27,
    parameter int FIFO_AWIDTH    = 10,
    parameter int OUTSTANDING    = 4
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      s0_arvalid,
    output logic                      s0_arready,
    input  logic [ADDR_WIDTH-1:0]     s0_araddr,
    input  logic [LEN_WIDTH-1:0]      s0_arlen,
    input  logic                      s1_arvalid,
    output logic                      s1_arready,
    input  logic [ADDR_WIDTH-1:0]     s1_araddr,
    input  logic [LEN_WIDTH-1:0]      s1_arlen,
    output logic                      cmd_valid,
    input  logic                      cmd_ready,
    output logic [ADDR_WIDTH-1:0]     cmd_addr,
    output logic [LEN_WIDTH-1:0]      cmd_len,
    input  logic                      f_rvalid,
    output logic                      f_rready,
    input  logic [AXI_DATA_WIDTH:0]   f_rdata,
    output logic                      s0_rvalid,
    input  logic                      s0_rready,
    output logic [AXI_DATA_WIDTH-1:0] s0_rdata,
    output logic                      s0_rlast,
    output logic                      s1_rvalid,
    input  logic                      s1_rready,
    output logic [AXI_DATA_WIDTH-1:0] s1_rdata,
    output logic                      s1_rlast
);

    localparam int             CW          = credit_width(FIFO_AWIDTH);
    localparam logic [CW-1:0]  CREDIT_FULL = CW'((1 << FIFO_AWIDTH) - 1);

    state_t                state;
    state_t                state_next;
    logic                  prio;
    logic [CW-1:0]         credit;
    logic [CW-1:0]         credit_next;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic                  pass0;
    logic                  pass1;
    logic                  grant;
    logic                  win;
    logic [LEN_WIDTH-1:0]  win_len;
    logic                  q_full;
    logic                  q_empty;
    logic [ID_WIDTH-1:0]   q_head;
    logic                  beat_fire;
    logic                  last_pop;

    function automatic logic credit_ok(input logic [CW-1:0] cr, input logic [LEN_WIDTH-1:0] len);
        return 32'(cr) >= 32'(len) + 32'd1;
    endfunction

    // Each requester is judged on its own, so one that cannot be admitted never blocks the other.
    assign pass0   = s0_arvalid && credit_ok(credit, s0_arlen) && !q_full;
    assign pass1   = s1_arvalid && credit_ok(credit, s1_arlen) && !q_full;
    assign win_len = win ? s1_arlen : s0_arlen;

    // NOTE: every always_comb output gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        win        = 1'b0;
        s0_arready = 1'b0;
        s1_arready = 1'b0;
        cmd_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (pass0 || pass1) begin
                    grant      = 1'b1;
                    win        = (pass0 && pass1) ? prio : pass1;
                    s0_arready = !win;
                    s1_arready = win;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                cmd_valid = 1'b1;
                if (cmd_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Admission guarantees credit >= arlen+1, so the net update can never wrap below zero.
    assign credit_next = credit
                       - (grant ? CW'(32'(win_len) + 32'd1) : '0)
                       + CW'(beat_fire);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            prio   <= 1'b0;
            credit <= CREDIT_FULL;
            addr_q <= '0;
            len_q  <= '0;
        end else begin
            state  <= state_next;
            credit <= credit_next;
            if (grant) begin
                prio   <= !win;
                addr_q <= win ? s1_araddr : s0_araddr;
                len_q  <= win_len;
            end
        end
    end

    assign cmd_addr = addr_q;
    assign cmd_len  = len_q;

    ddr_id_queue #(
        .DEPTH (OUTSTANDING),
        .WIDTH (ID_WIDTH)
    ) u_id_queue (
        .clk     (clk),
        .rstn    (rstn),
        .push    (grant),
        .push_id (ID_WIDTH'(win)),
        .pop     (last_pop),
        .head    (q_head),
        .full    (q_full),
        .empty   (q_empty)
    );

    // Returning beats belong to the oldest outstanding burst, whose owner is the queue head.
    assign f_rready  = (q_head[0] ? s1_rready : s0_rready) && !q_empty;
    assign s0_rvalid = f_rvalid && !q_empty && !q_head[0];
    assign s1_rvalid = f_rvalid && !q_empty && q_head[0];
    assign s0_rdata  = f_rdata[AXI_DATA_WIDTH-1:0];
    assign s1_rdata  = f_rdata[AXI_DATA_WIDTH-1:0];
    assign s0_rlast  = f_rdata[AXI_DATA_WIDTH];
    assign s1_rlast  = f_rdata[AXI_DATA_WIDTH];
    assign beat_fire = f_rvalid && f_rready;
    assign last_pop  = beat_fire && f_rdata[AXI_DATA_WIDTH];

endmodule

// File: tb/tb_ddr_read_scheduler.sv
// Scoreboard bench for ddr_read_scheduler: expected grants, commands and beats are queued as
// stimulus is driven and compared when the DUT produces them; a small-FIFO copy covers credit stalls.
`timescale 1ns/1ps
module tb_ddr_read_scheduler;

    localparam int AW = 27;
    localparam int DW = 16;

    typedef struct {
        bit            id;
        logic [AW-1:0] addr;
        logic [7:0]    len;
    } cmd_t;

    typedef struct {
        bit            id;
        logic [DW-1:0] data;
        bit            last;
    } beat_t;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic          s0_arvalid, s0_arready, s1_arvalid, s1_arready;
    logic [AW-1:0] s0_araddr, s1_araddr, cmd_addr;
    logic [7:0]    s0_arlen, s1_arlen, cmd_len;
    logic          cmd_valid, cmd_ready, f_rvalid, f_rready;
    logic [DW:0]   f_rdata;
    logic          s0_rvalid, s0_rready, s0_rlast, s1_rvalid, s1_rready, s1_rlast;
    logic [DW-1:0] s0_rdata, s1_rdata;

    logic          s0_arvalid_b, s0_arready_b, s1_arvalid_b, s1_arready_b;
    logic [AW-1:0] s0_araddr_b, s1_araddr_b, cmd_addr_b;
    logic [7:0]    s0_arlen_b, s1_arlen_b, cmd_len_b;
    logic          cmd_valid_b, cmd_ready_b, f_rvalid_b, f_rready_b;
    logic [DW:0]   f_rdata_b;
    logic          s0_rvalid_b, s0_rready_b, s0_rlast_b, s1_rvalid_b, s1_rready_b, s1_rlast_b;
    logic [DW-1:0] s0_rdata_b, s1_rdata_b;

    ddr_read_scheduler dut (
        .clk(clk), .rstn(rstn),
        .s0_arvalid(s0_arvalid), .s0_arready(s0_arready), .s0_araddr(s0_araddr), .s0_arlen(s0_arlen),
        .s1_arvalid(s1_arvalid), .s1_arready(s1_arready), .s1_araddr(s1_araddr), .s1_arlen(s1_arlen),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .f_rvalid(f_rvalid), .f_rready(f_rready), .f_rdata(f_rdata),
        .s0_rvalid(s0_rvalid), .s0_rready(s0_rready), .s0_rdata(s0_rdata), .s0_rlast(s0_rlast),
        .s1_rvalid(s1_rvalid), .s1_rready(s1_rready), .s1_rdata(s1_rdata), .s1_rlast(s1_rlast)
    );

    // A 31-entry FIFO lets the bench reach a credit level where a long burst must wait.
    ddr_read_scheduler #(.FIFO_AWIDTH(5)) dut_b (
        .clk(clk), .rstn(rstn),
        .s0_arvalid(s0_arvalid_b), .s0_arready(s0_arready_b), .s0_araddr(s0_araddr_b), .s0_arlen(s0_arlen_b),
        .s1_arvalid(s1_arvalid_b), .s1_arready(s1_arready_b), .s1_araddr(s1_araddr_b), .s1_arlen(s1_arlen_b),
        .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_addr(cmd_addr_b), .cmd_len(cmd_len_b),
        .f_rvalid(f_rvalid_b), .f_rready(f_rready_b), .f_rdata(f_rdata_b),
        .s0_rvalid(s0_rvalid_b), .s0_rready(s0_rready_b), .s0_rdata(s0_rdata_b), .s0_rlast(s0_rlast_b),
        .s1_rvalid(s1_rvalid_b), .s1_rready(s1_rready_b), .s1_rdata(s1_rdata_b), .s1_rlast(s1_rlast_b)
    );

    cmd_t  exp_grant[$];
    cmd_t  exp_cmd[$];
    beat_t exp_beat[$];
    int    n_cmp    = 0;
    int    n_bad    = 0;
    int    n_grants = 0;
    bit    mon_en   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_grant(input bit id, input logic [AW-1:0] addr, input logic [7:0] len);
        cmd_t c;
        c.id = id; c.addr = addr; c.len = len;
        exp_grant.push_back(c);
    endtask

    // Called at posedge+1; returns at posedge+1 after the grant edge with arvalid dropped.
    task automatic request(input bit id, input logic [AW-1:0] addr, input logic [7:0] len);
        int t = 0;
        expect_grant(id, addr, len);
        if (id) begin s1_arvalid = 1'b1; s1_araddr = addr; s1_arlen = len; end
        else    begin s0_arvalid = 1'b1; s0_araddr = addr; s0_arlen = len; end
        forever begin
            @(negedge clk);
            if (id ? s1_arready : s0_arready) break;
            if (++t > 2000) begin check("grant_timeout", 32'd0, 32'd1); break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        if (id) s1_arvalid = 1'b0; else s0_arvalid = 1'b0;
    endtask

    task automatic beat(input bit id, input logic [DW-1:0] data, input bit last);
        beat_t b;
        int t = 0;
        b.id = id; b.data = data; b.last = last;
        exp_beat.push_back(b);
        f_rvalid = 1'b1;
        f_rdata  = {last, data};
        forever begin
            @(negedge clk);
            if (f_rready) break;
            if (++t > 2000) begin check("beat_timeout", 32'd0, 32'd1); break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        f_rvalid = 1'b0;
    endtask

    task automatic burst(input bit id, input logic [DW-1:0] base, input int beats);
        for (int i = 0; i < beats; i++) beat(id, base + DW'(i), i == beats - 1);
    endtask

    task automatic sb_beat(input bit id, input logic [DW-1:0] data, input bit last);
        beat_t b;
        if (exp_beat.size() == 0) begin
            check("unexpected_beat", 32'd1, 32'd0);
        end else begin
            b = exp_beat.pop_front();
            check("beat_port", {31'd0, id}, {31'd0, b.id});
            check("beat_data", {16'd0, data}, {16'd0, b.data});
            check("beat_last", {31'd0, last}, {31'd0, b.last});
        end
    endtask

    // Monitor: samples main-DUT outputs on the falling edge and retires scoreboard entries.
    initial begin : monitor
        cmd_t g;
        forever begin
            @(negedge clk);
            if (mon_en && rstn) begin
                if (s0_arready || s1_arready) begin
                    n_grants++;
                    if (exp_grant.size() == 0) begin
                        check("unexpected_grant", {30'd0, s0_arready, s1_arready}, 32'd0);
                    end else begin
                        g = exp_grant.pop_front();
                        check("grant_port", {30'd0, s0_arready, s1_arready}, g.id ? 32'd1 : 32'd2);
                        exp_cmd.push_back(g);
                    end
                end
                if (cmd_valid && cmd_ready) begin
                    if (exp_cmd.size() == 0) begin
                        check("unexpected_cmd", 32'd1, 32'd0);
                    end else begin
                        g = exp_cmd.pop_front();
                        check("cmd_addr", {5'd0, cmd_addr}, {5'd0, g.addr});
                        check("cmd_len", {24'd0, cmd_len}, {24'd0, g.len});
                    end
                end
                if (s0_rvalid && s0_rready) sb_beat(1'b0, s0_rdata, s0_rlast);
                if (s1_rvalid && s1_rready) sb_beat(1'b1, s1_rdata, s1_rlast);
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d compared / %0d bad so far", n_cmp, n_bad);
        $fatal(1);
    end

    initial begin : stimulus
        bit held;
        int base;
        int hs;
        int t;
        rstn = 1'b0;
        s0_arvalid = 0; s0_araddr = '0; s0_arlen = '0; s1_arvalid = 0; s1_araddr = '0; s1_arlen = '0;
        cmd_ready = 1; f_rvalid = 0; f_rdata = '0; s0_rready = 1; s1_rready = 1;
        s0_arvalid_b = 0; s0_araddr_b = '0; s0_arlen_b = '0; s1_arvalid_b = 0; s1_araddr_b = '0; s1_arlen_b = '0;
        cmd_ready_b = 1; f_rvalid_b = 0; f_rdata_b = '0; s0_rready_b = 1; s1_rready_b = 1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
        check("rst_outputs", {27'd0, s0_arready, s1_arready, s0_rvalid, s1_rvalid, f_rready}, 32'd0);
        check("rst_cmd_addr_len", {5'd0, cmd_addr} | {24'd0, cmd_len}, 32'd0);
        check("rst_credit", 32'(dut.credit), 32'd1023);
        rstn   = 1'b1;
        mon_en = 1'b1;
        step(2);

        // Single burst: arready this cycle, command next cycle, credit 1023-4
        expect_grant(1'b0, 27'h100, 8'd3);
        s0_arvalid = 1; s0_araddr = 27'h100; s0_arlen = 8'd3;
        @(negedge clk); check("t1_arready", {31'd0, s0_arready}, 32'd1);
        @(posedge clk); #1; s0_arvalid = 0;
        check("t1_credit", 32'(dut.credit), 32'd1019);
        @(negedge clk); check("t1_cmd_valid", {31'd0, cmd_valid}, 32'd1);
        step(1);
        check("t1_cmd_done", {31'd0, cmd_valid}, 32'd0);

        // Command held while cmd_ready is low; no arready during ISSUE
        cmd_ready = 0;
        expect_grant(1'b1, 27'h200, 8'd0);
        s1_arvalid = 1; s1_araddr = 27'h200; s1_arlen = 8'd0;
        @(negedge clk); check("t2_arready", {31'd0, s1_arready}, 32'd1);
        @(posedge clk); #1; s1_arvalid = 0;
        expect_grant(1'b0, 27'h300, 8'd0);
        s0_arvalid = 1; s0_araddr = 27'h300; s0_arlen = 8'd0;
        repeat (3) begin
            @(negedge clk);
            check("t2_hold", {29'd0, cmd_valid, s0_arready, s1_arready}, 32'd4);
            check("t2_addr", {5'd0, cmd_addr}, 32'h200);
            @(posedge clk); #1;
        end
        cmd_ready = 1;
        step(1);
        @(negedge clk); check("t2_next_grant", {31'd0, s0_arready}, 32'd1);
        @(posedge clk); #1; s0_arvalid = 0;
        step(1);

        // Return data routed by ID order; credit fully restored
        burst(1'b0, 16'hA000, 4);
        burst(1'b1, 16'hB000, 1);
        burst(1'b0, 16'hC000, 1);
        check("t3_credit", 32'(dut.credit), 32'd1023);
        f_rvalid = 1; f_rdata = {1'b1, 16'h5555};
        @(negedge clk); check("t3_empty_gate", {29'd0, f_rready, s0_rvalid, s1_rvalid}, 32'd0);
        @(posedge clk); #1; f_rvalid = 0;

        // Reset restores priority to s0; both requesting continuously alternate
        rstn = 0;
        step(2);
        rstn = 1;
        step(1);
        expect_grant(1'b0, 27'h10, 8'd0);
        expect_grant(1'b1, 27'h20, 8'd0);
        expect_grant(1'b0, 27'h10, 8'd0);
        expect_grant(1'b1, 27'h20, 8'd0);
        base = n_grants;
        t    = 0;
        s0_arvalid = 1; s0_araddr = 27'h10; s0_arlen = 8'd0;
        s1_arvalid = 1; s1_araddr = 27'h20; s1_arlen = 8'd0;
        while (n_grants < base + 4 && t < 100) begin
            step(1);
            t++;
        end
        check("t4_four_grants", 32'(n_grants - base), 32'd4);
        s0_arvalid = 0; s1_arvalid = 0;

        // Fifth request stalls on a full ID queue, resumes the cycle after the first rlast pop
        expect_grant(1'b0, 27'h40, 8'd0);
        s0_arvalid = 1; s0_araddr = 27'h40; s0_arlen = 8'd0;
        held = 0;
        repeat (5) begin
            @(negedge clk); held |= s0_arready;
            @(posedge clk); #1;
        end
        check("t5_stall", {31'd0, held}, 32'd0);
        begin
            beat_t b;
            b.id = 1'b0; b.data = 16'hD000; b.last = 1'b1;
            exp_beat.push_back(b);
        end
        f_rvalid = 1; f_rdata = {1'b1, 16'hD000};
        @(negedge clk);
        check("t5_pop_ready", {31'd0, f_rready}, 32'd1);
        check("t5_still_stalled", {31'd0, s0_arready}, 32'd0);
        @(posedge clk); #1; f_rvalid = 0;
        @(negedge clk); check("t5_resume", {31'd0, s0_arready}, 32'd1);
        @(posedge clk); #1; s0_arvalid = 0;
        step(1);
        beat(1'b1, 16'hE001, 1'b1);
        beat(1'b0, 16'hE002, 1'b1);
        beat(1'b1, 16'hE003, 1'b1);
        beat(1'b0, 16'hE004, 1'b1);
        check("t5_credit", 32'(dut.credit), 32'd1023);

        // 256-beat burst admitted at full credit, then s0 len1 / s1 len0 style return
        request(1'b0, 27'h1000, 8'd255);
        check("t6_credit_256", 32'(dut.credit), 32'd767);
        step(1);
        request(1'b1, 27'h2000, 8'd0);
        check("t6_credit_257", 32'(dut.credit), 32'd766);
        step(1);
        burst(1'b0, 16'h0000, 256);
        burst(1'b1, 16'h7777, 1);
        check("t6_credit_back", 32'(dut.credit), 32'd1023);

        // Reset during a stalled ISSUE drops the command asynchronously
        cmd_ready = 0;
        request(1'b1, 27'h555, 8'd7);
        @(negedge clk); check("t7_cmd_pending", {31'd0, cmd_valid}, 32'd1);
        #2 rstn = 0;
        #1 check("t7_async_drop", {31'd0, cmd_valid}, 32'd0);
        exp_cmd.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstn = 1; cmd_ready = 1;
        check("t7_credit", 32'(dut.credit), 32'd1023);
        f_rvalid = 1; f_rdata = {1'b1, 16'h1234};
        @(negedge clk); check("t7_queue_empty", {29'd0, f_rready, s0_rvalid, s1_rvalid}, 32'd0);
        @(posedge clk); #1; f_rvalid = 0;

        // Small-FIFO copy: s0 needs 16 credits, has 10 -> s1 wins, s0 waits for 16 free beats
        check("b_rst_credit", 32'(dut_b.credit), 32'd31);
        s1_arvalid_b = 1; s1_arlen_b = 8'd20;
        @(negedge clk); check("b_first_grant", {31'd0, s1_arready_b}, 32'd1);
        @(posedge clk); #1; s1_arvalid_b = 0;
        check("b_credit10", 32'(dut_b.credit), 32'd10);
        step(1);
        s0_arvalid_b = 1; s0_arlen_b = 8'd15;
        s1_arvalid_b = 1; s1_arlen_b = 8'd3;
        @(negedge clk); check("b_s1_wins", {30'd0, s0_arready_b, s1_arready_b}, 32'd1);
        @(posedge clk); #1; s1_arvalid_b = 0;
        held = 0;
        hs   = 0;
        f_rvalid_b = 1; f_rdata_b = {1'b0, 16'h0042};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            held |= s0_arready_b;
            hs   += int'(f_rready_b);
            @(posedge clk); #1;
        end
        f_rvalid_b = 0;
        check("b_s0_held", {31'd0, held}, 32'd0);
        check("b_beats_popped", 32'(hs), 32'd10);
        @(negedge clk); check("b_s0_resume", {31'd0, s0_arready_b}, 32'd1);
        @(posedge clk); #1; s0_arvalid_b = 0;
        step(2);

        check("sb_drained", 32'(exp_grant.size() + exp_cmd.size() + exp_beat.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
